// File: rtl/mem_island_init_ctrl.sv
// Region init/scrub sequencer driving one narrow memory-island request port.
// Define MEM_ISLAND_INIT_VERIFY_EN to add read-back verify (VERIFY/DRAIN, compare pipeline).
module mem_island_init_ctrl #(
  parameter int unsigned          AddrWidth   = 32,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [AddrWidth-1:0] BaseAddr    = '0,
  parameter int unsigned          NumWords    = 1024,
  parameter int unsigned          ReadLatency = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic                   mode_i,
  input  logic [DataWidth-1:0]   pattern_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [AddrWidth-1:0]   err_addr_o,
  output logic                   req_valid_o,
  input  logic                   req_ready_i,
  output logic [AddrWidth-1:0]   req_addr_o,
  output logic                   req_write_o,
  output logic [DataWidth-1:0]   req_data_o,
  output logic [DataWidth/8-1:0] req_strb_o,
  input  logic [DataWidth-1:0]   rsp_data_i
);
  localparam int unsigned IdxW    = $clog2(NumWords) + 1;
  localparam int unsigned ByteOff = $clog2(DataWidth / 8);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_VERIFY, S_DRAIN, S_FINISH} state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 mode_q;
  logic [DataWidth-1:0] pattern_q;
  logic                 abort_q;
  logic                 issuing, hs, last, abort_now;
  logic [DataWidth-1:0] word_data;
  logic [AddrWidth-1:0] word_addr;

  assign issuing   = (state_q == S_WRITE) || (state_q == S_VERIFY);
  assign hs        = issuing && req_ready_i;
  assign last      = (idx_q == IdxW'(NumWords - 1));
  assign abort_now = abort_q || abort_i;
  assign word_addr = BaseAddr + (AddrWidth'(idx_q) << ByteOff);
  assign word_data = mode_q ? (pattern_q ^ DataWidth'(idx_q)) : pattern_q;

  // Payload is a pure function of idx and the latched run config, so it holds through stalls.
  assign req_valid_o = issuing;
  assign req_write_o = (state_q == S_WRITE);
  assign req_addr_o  = issuing ? word_addr : '0;
  assign req_data_o  = issuing ? word_data : '0;
  assign req_strb_o  = '1;
  assign busy_o      = issuing || (state_q == S_DRAIN);
  assign done_o      = (state_q == S_FINISH);

`ifdef MEM_ISLAND_INIT_VERIFY_EN
  logic [ReadLatency-1:0] pipe_valid;
  logic [DataWidth-1:0]   pipe_exp  [ReadLatency];
  logic [AddrWidth-1:0]   pipe_addr [ReadLatency];
  logic                   mismatch, drain_done;
  logic                   error_q;
  logic [AddrWidth-1:0]   err_addr_q;

  assign mismatch   = pipe_valid[ReadLatency-1] && (rsp_data_i != pipe_exp[ReadLatency-1]);
  // Leave DRAIN as the youngest entry reaches the tail; it is compared in that same cycle.
  assign drain_done = ((pipe_valid << 1) == '0);
  assign error_o    = error_q;
  assign err_addr_o = err_addr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pipe_valid <= '0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
    end else begin
      pipe_valid[0] <= hs && (state_q == S_VERIFY);
      for (int unsigned i = 1; i < ReadLatency; i++) pipe_valid[i] <= pipe_valid[i-1];
      if ((state_q == S_IDLE) && start_i) begin
        error_q    <= 1'b0;
        err_addr_q <= '0;
      end else if (mismatch && !error_q) begin
        error_q    <= 1'b1;
        err_addr_q <= pipe_addr[ReadLatency-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    pipe_exp[0]  <= word_data;
    pipe_addr[0] <= word_addr;
    for (int unsigned i = 1; i < ReadLatency; i++) begin
      pipe_exp[i]  <= pipe_exp[i-1];
      pipe_addr[i] <= pipe_addr[i-1];
    end
  end
`else
  logic unused_rsp;
  assign unused_rsp = ^rsp_data_i ^ (ReadLatency == 0);
  assign error_o    = 1'b0;
  assign err_addr_o = '0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_WRITE;
          idx_d   = '0;
        end
      end
      S_WRITE: begin
        if (hs) begin
          idx_d = idx_q + IdxW'(1);
          if (abort_now || last) idx_d = '0;
`ifdef MEM_ISLAND_INIT_VERIFY_EN
          if (abort_now)  state_d = S_DRAIN;
          else if (last)  state_d = S_VERIFY;
`else
          if (abort_now)  state_d = S_IDLE;
          else if (last)  state_d = S_FINISH;
`endif
        end
      end
`ifdef MEM_ISLAND_INIT_VERIFY_EN
      S_VERIFY: begin
        if (hs) begin
          idx_d = idx_q + IdxW'(1);
          if (abort_now || last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_done) state_d = abort_now ? S_IDLE : S_FINISH;
      end
`endif
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      mode_q    <= 1'b0;
      pattern_q <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == S_IDLE) begin
        // A start with abort already asserted still performs its first handshake.
        if (start_i) begin
          mode_q    <= mode_i;
          pattern_q <= pattern_i;
          abort_q   <= abort_i;
        end
      end else if (abort_i) begin
        abort_q <= 1'b1;
      end
    end
  end
endmodule
